// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time. It synchronises
// and debounces the row lines and reports each accepted press exactly once.
// After a press it waits for the key to be released, with debounce, before
// scanning resumes.
//
// Parameters:
//   SCAN_CYCLES     - dwell cycles per column before rows are sampled (>=3)
//   DEBOUNCE_CYCLES - consecutive stable cycles to accept a press/release (1-255)
//   CLEAR_CODE      - key code routed to 'clear' when KEYPAD_CLEAR_KEY_EN is defined
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   rows   in   [3:0] keypad rows, asynchronous, active-low
//   cols   out  [3:0] column drive, exactly one bit low
//   digit  out  [3:0] code of last accepted key, 4*row + col
//   valid  out  one-cycle pulse when digit is updated
//   clear  out  one-cycle pulse for the clear key (KEYPAD_CLEAR_KEY_EN builds)
//
// Build option: define KEYPAD_CLEAR_KEY_EN to report CLEAR_CODE on 'clear'
// instead of 'valid'. In that case 'digit' is left untouched. When the macro
// is undefined, 'clear' is tied low.
module keypad_scanner #(
    parameter int         SCAN_CYCLES     = 4,
    parameter int         DEBOUNCE_CYCLES = 4,
    parameter logic [3:0] CLEAR_CODE      = 4'hF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] digit,
    output logic       valid,
    output logic       clear
);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE} state_t;

    localparam logic [7:0] DWELL_LAST = 8'(SCAN_CYCLES - 1);
    localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] rows_m, rows_s;
    logic [1:0] col_idx, col_idx_nxt;
    logic [1:0] r, r_nxt, c, c_nxt;
    logic [7:0] dwell, dwell_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [3:0] digit_nxt;
    logic       valid_nxt;
    logic [1:0] low_row;

    // Column drive follows the column index directly, so an asynchronous
    // reset of col_idx also returns cols to 4'b1110 without a clock.
    assign cols = ~(4'b0001 << col_idx);

    // Lowest-index low row wins when several keys share the active column.
    always_comb begin
        low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_s[i]) low_row = 2'(i);
        end
    end

    always_comb begin
        state_nxt   = state;
        col_idx_nxt = col_idx;
        dwell_nxt   = dwell;
        cnt_nxt     = cnt;
        r_nxt       = r;
        c_nxt       = c;
        digit_nxt   = digit;
        valid_nxt   = 1'b0;
        case (state)
            SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_nxt = 8'd0;
                    if (rows_s != 4'hF) begin
                        r_nxt     = low_row;
                        c_nxt     = col_idx;
                        cnt_nxt   = 8'd0;
                        state_nxt = DEBOUNCE;
                    end else begin
                        col_idx_nxt = col_idx + 2'd1;
                    end
                end else begin
                    dwell_nxt = dwell + 8'd1;
                end
            end
            DEBOUNCE: begin
                if (rows_s[r]) begin
                    // Bounce: give up on this key and move on.
                    cnt_nxt     = 8'd0;
                    col_idx_nxt = col_idx + 2'd1;
                    state_nxt   = SCAN;
                end else if (cnt == DEB_LAST) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = EMIT;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            EMIT: begin
                cnt_nxt   = 8'd0;
                state_nxt = WAIT_RELEASE;
`ifndef KEYPAD_CLEAR_KEY_EN
                digit_nxt = {r, c};
                valid_nxt = 1'b1;
`else
                if ({r, c} != CLEAR_CODE) begin
                    digit_nxt = {r, c};
                    valid_nxt = 1'b1;
                end
`endif
            end
            WAIT_RELEASE: begin
                if (!rows_s[r]) begin
                    cnt_nxt = 8'd0;
                end else if (cnt == DEB_LAST) begin
                    cnt_nxt     = 8'd0;
                    col_idx_nxt = col_idx + 2'd1;
                    state_nxt   = SCAN;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows_m  <= 4'hF;
            rows_s  <= 4'hF;
            state   <= SCAN;
            col_idx <= 2'd0;
            dwell   <= 8'd0;
            cnt     <= 8'd0;
            r       <= 2'd0;
            c       <= 2'd0;
            digit   <= 4'd0;
            valid   <= 1'b0;
        end else begin
            rows_m  <= rows;
            rows_s  <= rows_m;
            state   <= state_nxt;
            col_idx <= col_idx_nxt;
            dwell   <= dwell_nxt;
            cnt     <= cnt_nxt;
            r       <= r_nxt;
            c       <= c_nxt;
            digit   <= digit_nxt;
            valid   <= valid_nxt;
        end
    end

`ifdef KEYPAD_CLEAR_KEY_EN
    // The clear key is reported on its own registered strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) clear <= 1'b0;
        else        clear <= (state == EMIT) && ({r, c} == CLEAR_CODE);
    end
`else
    assign clear = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    localparam int SC = 4;
    localparam int D  = 4;
`ifdef KEYPAD_CLEAR_KEY_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  rows, cols, digit;
    logic        valid, clear;
    logic [15:0] pressed = 16'h0;

    int n_cmp = 0;
    int n_err = 0;
    int vcount = 0;
    int ccount = 0;
    logic prev_v = 1'b0;

    keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(D), .CLEAR_CODE(4'hF)) dut (
        .clk(clk), .reset(reset), .rows(rows), .cols(cols),
        .digit(digit), .valid(valid), .clear(clear)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its row low while its column is driven.
    always_comb begin
        rows = 4'hF;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (pressed[rr*4+cc] && !cols[cc]) rows[rr] = 1'b0;
    end

    // Pulse counter and per-cycle output sanity checks.
    always @(negedge clk) begin
        n_cmp++;
        if ($countones(~cols) != 1) begin
            n_err++;
            $display("FAIL cols_onehot: got %b, required exactly one low bit", cols);
        end
        if (valid) begin
            vcount++;
            n_cmp++;
            if (prev_v || clear) begin
                n_err++;
                $display("FAIL valid_single: valid longer than one cycle or with clear (prev=%b clear=%b)", prev_v, clear);
            end
        end
        if (clear) ccount++;
        prev_v = valid;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset with the given keys already held; releases reset on a falling
    // edge, so the next rising edge is edge 1.
    task automatic restart(input logic [15:0] keys);
        reset = 1'b0;
        pressed = keys;
        #2;
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        int row;
        int col;
        int exp_digit;
        int exp_v;
        int exp_c;
        int exp_lat;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int v0, c0, lat, key, hold, gap, exp_dig;
        bit is_clr;

        // Reset state.
        #3;
        chk("rst_cols", cols, 4'b1110);
        chk("rst_digit", digit, 0);
        chk("rst_valid", valid, 0);
        chk("rst_clear", clear, 0);

        // Single presses from reset. Latency is measured in edges after
        // reset release, which is the key's column slot plus debounce.
        tbl[0] = '{2, 1, 9, 1, 0, 0};
        tbl[1] = '{0, 3, 3, 1, 0, 0};
        tbl[2] = '{1, 0, 4, 1, 0, 0};
        tbl[3] = '{3, 2, 14, 1, 0, 0};
        tbl[4] = '{0, 0, 0, 1, 0, 0};
        tbl[5] = '{3, 3, CLR_EN ? 0 : 15, CLR_EN ? 0 : 1, CLR_EN ? 1 : 0, 0};
        tbl[6] = '{1, 2, 6, 1, 0, 0};
        for (int i = 0; i < 7; i++) tbl[i].exp_lat = SC * (tbl[i].col + 1) + D + 1;

        for (int i = 0; i < 7; i++) begin
            lat = -1;
            restart(16'(1) << (tbl[i].row * 4 + tbl[i].col));
            v0 = vcount;
            c0 = ccount;
            for (int e = 1; e <= 40; e++) begin
                edges(1);
                if (lat < 0 && (valid || clear)) lat = e;
            end
            chk("tbl_latency", lat, tbl[i].exp_lat);
            chk("tbl_cols_held", cols, 15 & ~(1 << tbl[i].col));
            pressed = 16'h0;
            edges(30);
            chk("tbl_valid_cnt", vcount - v0, tbl[i].exp_v);
            chk("tbl_clear_cnt", ccount - c0, tbl[i].exp_c);
            chk("tbl_digit", digit, tbl[i].exp_digit);
        end

        // Reset while debouncing: key 9 accepted, then key 6 caught mid-debounce.
        restart(16'h0200);
        edges(13);
        chk("rstseq_valid", valid, 1);
        chk("rstseq_digit", digit, 9);
        edges(7);
        pressed = 16'h0040;
        edges(12);
        chk("rstseq_cols_pre", cols, 4'b1011);
        #1 reset = 1'b0;
        #1;
        chk("rstseq_cols_async", cols, 4'b1110);
        chk("rstseq_digit_async", digit, 0);
        chk("rstseq_valid_async", valid, 0);
        chk("rstseq_clear_async", clear, 0);
        v0 = vcount;
        c0 = ccount;
        pressed = 16'h0;
        @(negedge clk);
        reset = 1'b1;
        edges(3);
        chk("rstseq_col0", cols, 4'b1110);
        edges(1);
        chk("rstseq_col1", cols, 4'b1101);
        edges(36);
        chk("rstseq_no_pulse", (vcount - v0) + (ccount - c0), 0);

        // Press bounce: row low for D-1 debounce cycles, then high.
        restart(16'h0020);
        v0 = vcount;
        edges(9);
        pressed = 16'h0;
        edges(2);
        chk("pbounce_cols_hold", cols, 4'b1101);
        edges(1);
        chk("pbounce_cols_adv", cols, 4'b1011);
        edges(30);
        chk("pbounce_no_valid", vcount - v0, 0);

        // Release bounce, then a clean press of key 3.
        restart(16'h0200);
        v0 = vcount;
        edges(13);
        chk("rbounce_valid9", valid, 1);
        chk("rbounce_digit9", digit, 9);
        edges(7);
        pressed = 16'h0;
        edges(2);
        pressed = 16'h0200;
        edges(2);
        pressed = 16'h0008;
        edges(5);
        chk("rbounce_cols_hold", cols, 4'b1101);
        edges(1);
        chk("rbounce_cols_adv", cols, 4'b1011);
        edges(12);
        chk("rbounce_valid3_early", valid, 0);
        edges(1);
        chk("rbounce_valid3", valid, 1);
        chk("rbounce_digit3", digit, 3);
        pressed = 16'h0;
        edges(30);
        chk("rbounce_pulse_cnt", vcount - v0, 2);

        // Two keys in column 0: row 1 wins, row 3 reported after row 1 released.
        restart(16'h1010);
        v0 = vcount;
        edges(9);
        chk("twokey_valid4", valid, 1);
        chk("twokey_digit4", digit, 4);
        edges(11);
        pressed = 16'h1000;
        edges(26);
        chk("twokey_validC_early", valid, 0);
        edges(1);
        chk("twokey_validC", valid, 1);
        chk("twokey_digitC", digit, 12);
        pressed = 16'h0;
        edges(30);
        chk("twokey_pulse_cnt", vcount - v0, 2);

        // Random presses at arbitrary scan phase against a press-level model:
        // each press gives one pulse of the right kind within a full scan
        // round plus sync and debounce, and digit tracks the last non-clear key.
        restart(16'h0);
        edges(10);
        exp_dig = 0;
        for (int k = 0; k < 24; k++) begin
            key  = (k == 0) ? 5 : (k == 1) ? 15 : int'($urandom_range(0, 15));
            hold = int'($urandom_range(30, 60));
            gap  = int'($urandom_range(10, 30));
            is_clr = CLR_EN && (key == 15);
            v0 = vcount;
            c0 = ccount;
            lat = -1;
            pressed = 16'(1) << key;
            for (int e = 1; e <= hold; e++) begin
                edges(1);
                if (lat < 0 && (valid || clear)) lat = e;
            end
            pressed = 16'h0;
            edges(gap);
            if (!is_clr) exp_dig = key;
            chk("rnd_valid_cnt", vcount - v0, is_clr ? 0 : 1);
            chk("rnd_clear_cnt", ccount - c0, is_clr ? 1 : 0);
            chk("rnd_digit", digit, exp_dig);
            chk("rnd_latency_in_bound", int'(lat > 0 && lat <= 4 * SC + D + 4), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
